// File: rtl/freelist_pkg.sv
// Shared sizes and types for the rename free list.
// FREELIST_DUPCHK_EN (see freelist.sv) enables the duplicate-tag checker.
package freelist_pkg;

   localparam int PREG_NUM = 64;
   localparam int LREG_NUM = 32;
   localparam int FL_DEPTH = PREG_NUM - LREG_NUM;
   localparam int PREG_W   = $clog2(PREG_NUM);
   localparam int IDX_W    = $clog2(FL_DEPTH);
   localparam int CNT_W    = IDX_W + 1;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [CNT_W-1:0]  fl_cnt_t;

   typedef struct packed {
      logic             wrap;
      logic [IDX_W-1:0] idx;
   } fl_ptr_t;

   function automatic logic [1:0] pop2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/fl_ptr_add.sv
// Wrap-aware free-list pointer increment (0..2) plus occupancy of the result
// measured from a base pointer.
module fl_ptr_add
   import freelist_pkg::*;
(
   input  fl_ptr_t    ptr_i,
   input  logic [1:0] inc_i,
   input  fl_ptr_t    base_i,
   output fl_ptr_t    sum_o,
   output fl_cnt_t    diff_o
);

   // The wrap bit rides along as the MSB, so plain modulo-2*DEPTH arithmetic works.
   assign sum_o  = fl_ptr_t'(fl_cnt_t'(ptr_i) + {{(CNT_W-2){1'b0}}, inc_i});
   assign diff_o = fl_cnt_t'(sum_o) - fl_cnt_t'(base_i);

endmodule

// File: rtl/freelist_chk.sv
// Simulation checker for the free list; with FREELIST_DUPCHK_EN it also keeps
// an is_free shadow vector to catch double frees and stale allocations.
module freelist_chk
   import freelist_pkg::*;
(
   input  logic    clock_i,
   input  logic    reset_i,
   input  logic    free0_valid_i,
   input  preg_t   free0_preg_i,
   input  logic    free1_valid_i,
   input  preg_t   free1_preg_i,
   input  logic    redirect_flush_i,
   input  fl_cnt_t count_q_i,
   input  fl_cnt_t head_lead_i,
   input  fl_cnt_t arch_vs_tail_i
`ifdef FREELIST_DUPCHK_EN
   ,
   input  logic    alloc0_i,
   input  logic    alloc1_i,
   input  preg_t   resp0_i,
   input  preg_t   resp1_i,
   input  logic    wr0_i,
   input  logic    wr1_i,
   input  fl_ptr_t head_d_i,
   input  fl_ptr_t tail_q_i,
   input  preg_t   slot_q_i [FL_DEPTH]
`endif
);

   logic [CNT_W:0] free_need_s;
   fl_cnt_t        tail_span_s;

   assign free_need_s = {1'b0, count_q_i} + {{(CNT_W-1){1'b0}}, pop2(free0_valid_i, free1_valid_i)};
   assign tail_span_s = {CNT_W{1'b0}} - arch_vs_tail_i;

   a_no_tag0: assert property (@(posedge clock_i) disable iff (reset_i)
      !(free0_valid_i && free0_preg_i == {PREG_W{1'b0}}) &&
      !(free1_valid_i && free1_preg_i == {PREG_W{1'b0}}));

   a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
      free_need_s <= (CNT_W+1)'(FL_DEPTH));

   a_arch_behind_head: assert property (@(posedge clock_i) disable iff (reset_i)
      redirect_flush_i || head_lead_i <= fl_cnt_t'(FL_DEPTH));

   a_ring_span: assert property (@(posedge clock_i) disable iff (reset_i)
      tail_span_s <= fl_cnt_t'(FL_DEPTH));

`ifdef FREELIST_DUPCHK_EN
   logic [PREG_NUM-1:0] is_free_q;
   logic [PREG_NUM-1:0] is_free_d;
   fl_cnt_t             span_s;

   assign span_s = fl_cnt_t'(tail_q_i) - fl_cnt_t'(head_d_i);

   // Next shadow state: flush rebuilds from the restored pointer range, then frees land.
   always_comb begin
      is_free_d = is_free_q;
      if (redirect_flush_i) begin
         is_free_d = {PREG_NUM{1'b0}};
         for (int i = 0; i < FL_DEPTH; i++) begin
            is_free_d[slot_q_i[head_d_i.idx + IDX_W'(i)]] =
               is_free_d[slot_q_i[head_d_i.idx + IDX_W'(i)]] | (CNT_W'(i) < span_s);
         end
      end else begin
         is_free_d[resp0_i] = is_free_d[resp0_i] & ~alloc0_i;
         is_free_d[resp1_i] = is_free_d[resp1_i] & ~alloc1_i;
      end
      is_free_d[free0_preg_i] = is_free_d[free0_preg_i] | wr0_i;
      is_free_d[free1_preg_i] = is_free_d[free1_preg_i] | wr1_i;
   end

   // Shadow register of which tags currently sit in the free list.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         is_free_q <= {{(PREG_NUM-LREG_NUM){1'b1}}, {LREG_NUM{1'b0}}};
      end else begin
         is_free_q <= is_free_d;
      end
   end

   a_no_double_free: assert property (@(posedge clock_i) disable iff (reset_i)
      !(wr0_i && is_free_q[free0_preg_i]) && !(wr1_i && is_free_q[free1_preg_i]) &&
      !(wr0_i && wr1_i && free0_preg_i == free1_preg_i));

   a_alloc_is_free: assert property (@(posedge clock_i) disable iff (reset_i)
      !(alloc0_i && !is_free_q[resp0_i]) && !(alloc1_i && !is_free_q[resp1_i]));
`endif

endmodule

// File: rtl/freelist.sv
// Two-wide physical-register free list with committed-head flush recovery.
// Optional duplicate-tag checking: define FREELIST_DUPCHK_EN.
module freelist
   import freelist_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       instr0_freelist_req,
   output preg_t      instr0_freelist_resp,
   input  logic       instr1_freelist_req,
   output preg_t      instr1_freelist_resp,
   output logic       freelist_can_alloc,
   input  logic       free0_valid,
   input  preg_t      free0_preg,
   input  logic       free1_valid,
   input  preg_t      free1_preg,
   input  logic [1:0] commit_alloc_cnt,
   input  logic       redirect_flush,
   output fl_cnt_t    freelist_count
);

   preg_t            slot_q [FL_DEPTH];
   fl_ptr_t          head_q, head_d, arch_head_q, arch_head_d, tail_q, tail_d;
   fl_ptr_t          head_sum_s;
   fl_cnt_t          count_q, count_d;
   fl_cnt_t          head_lead_s, arch_vs_tail_s;
   logic             can_alloc_q;
   logic             alloc_fire_s;
   logic [1:0]       nalloc_s, nfree_s;
   logic             free0_ok_s, free1_ok_s, overflow_s, wr0_s, wr1_s;
   logic [IDX_W-1:0] resp1_idx_s, tail1_idx_s;

   // All-or-nothing pop: stalled or flushed cycles leave head where it is.
   assign alloc_fire_s = can_alloc_q & ~redirect_flush;
   assign nalloc_s     = alloc_fire_s ? pop2(instr0_freelist_req, instr1_freelist_req) : 2'd0;

   assign free0_ok_s = free0_valid & (free0_preg != {PREG_W{1'b0}});
   assign free1_ok_s = free1_valid & (free1_preg != {PREG_W{1'b0}});
   assign overflow_s = ({1'b0, count_q} + {{(CNT_W-1){1'b0}}, pop2(free0_ok_s, free1_ok_s)})
                       > (CNT_W+1)'(FL_DEPTH);
   assign wr0_s      = free0_ok_s & ~overflow_s;
   assign wr1_s      = free1_ok_s & ~overflow_s;
   assign nfree_s    = pop2(wr0_s, wr1_s);

   assign resp1_idx_s = head_q.idx + {{(IDX_W-1){1'b0}}, instr0_freelist_req};
   assign tail1_idx_s = tail_q.idx + {{(IDX_W-1){1'b0}}, 1'b1};

   assign instr0_freelist_resp = slot_q[head_q.idx];
   assign instr1_freelist_resp = slot_q[resp1_idx_s];
   assign freelist_can_alloc   = can_alloc_q;
   assign freelist_count       = count_q;

   fl_ptr_add u_arch_add (
      .ptr_i  (arch_head_q),
      .inc_i  (commit_alloc_cnt),
      .base_i (tail_q),
      .sum_o  (arch_head_d),
      .diff_o (arch_vs_tail_s)
   );

   fl_ptr_add u_head_add (
      .ptr_i  (head_q),
      .inc_i  (nalloc_s),
      .base_i (arch_head_d),
      .sum_o  (head_sum_s),
      .diff_o (head_lead_s)
   );

   // Count falls out of the pointer difference, so flush recovery needs no special case.
   fl_ptr_add u_tail_add (
      .ptr_i  (tail_q),
      .inc_i  (nfree_s),
      .base_i (head_d),
      .sum_o  (tail_d),
      .diff_o (count_d)
   );

   // Flush rewinds head to the committed point, including this cycle's commits.
   always_comb begin
      head_d = head_sum_s;
      if (redirect_flush) begin
         head_d = arch_head_d;
      end else begin
         head_d = head_sum_s;
      end
   end

   // Storage, pointers and registered status.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            slot_q[i] <= preg_t'(LREG_NUM + i);
         end
         head_q      <= '{wrap: 1'b0, idx: {IDX_W{1'b0}}};
         arch_head_q <= '{wrap: 1'b0, idx: {IDX_W{1'b0}}};
         tail_q      <= '{wrap: 1'b1, idx: {IDX_W{1'b0}}};
         count_q     <= fl_cnt_t'(FL_DEPTH);
         can_alloc_q <= 1'b1;
      end else begin
         if (wr0_s) begin
            slot_q[tail_q.idx] <= free0_preg;
            if (wr1_s) begin
               slot_q[tail1_idx_s] <= free1_preg;
            end
         end else if (wr1_s) begin
            slot_q[tail_q.idx] <= free1_preg;
         end
         head_q      <= head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         can_alloc_q <= (count_d >= fl_cnt_t'(2));
      end
   end

   freelist_chk u_chk (
      .clock_i          (clock),
      .reset_i          (reset),
      .free0_valid_i    (free0_valid),
      .free0_preg_i     (free0_preg),
      .free1_valid_i    (free1_valid),
      .free1_preg_i     (free1_preg),
      .redirect_flush_i (redirect_flush),
      .count_q_i        (count_q),
      .head_lead_i      (head_lead_s),
      .arch_vs_tail_i   (arch_vs_tail_s)
`ifdef FREELIST_DUPCHK_EN
      ,
      .alloc0_i         (alloc_fire_s & instr0_freelist_req),
      .alloc1_i         (alloc_fire_s & instr1_freelist_req),
      .resp0_i          (instr0_freelist_resp),
      .resp1_i          (instr1_freelist_resp),
      .wr0_i            (wr0_s),
      .wr1_i            (wr1_s),
      .head_d_i         (head_d),
      .tail_q_i         (tail_q),
      .slot_q_i         (slot_q)
`endif
   );

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: a queue-based model of free, speculative and
// mapped tags predicts every cycle's outputs; a negedge monitor compares them.
module tb_freelist;
   import freelist_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       f0v = 1'b0, f1v = 1'b0, flush = 1'b0;
   preg_t      f0p = '0, f1p = '0;
   logic [1:0] cac = 2'd0;
   preg_t      resp0, resp1;
   logic       can_alloc;
   fl_cnt_t    count;

   freelist dut (
      .clock                (clock),
      .reset                (reset),
      .instr0_freelist_req  (req0),
      .instr0_freelist_resp (resp0),
      .instr1_freelist_req  (req1),
      .instr1_freelist_resp (resp1),
      .freelist_can_alloc   (can_alloc),
      .free0_valid          (f0v),
      .free0_preg           (f0p),
      .free1_valid          (f1v),
      .free1_preg           (f1p),
      .commit_alloc_cnt     (cac),
      .redirect_flush       (flush),
      .freelist_count       (count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int id;
      bit chk_resp;
      int r0;
      int r1;
      int cnt;
      bit can;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   step_id = 0;

   // Model: free tags in allocation order, allocated-but-uncommitted tags, releasable tags.
   int freeq[$];
   int specq[$];
   int mapped[$];

   function automatic void cmp(string name, int id, int act, int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, expv);
      end
   endfunction

   function automatic void model_reset();
      freeq.delete(); specq.delete(); mapped.delete();
      for (int t = LREG_NUM; t < PREG_NUM; t++) freeq.push_back(t);
      for (int t = 1; t < LREG_NUM; t++) mapped.push_back(t);
   endfunction

   function automatic void remove_mapped(int t);
      for (int i = 0; i < mapped.size(); i++) begin
         if (mapped[i] == t) begin
            mapped.delete(i);
            return;
         end
      end
   endfunction

   function automatic int auto_cc();
      return (specq.size() >= 2) ? 2 : specq.size();
   endfunction

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; f0v = 1'b0; f1v = 1'b0; flush = 1'b0; cac = 2'd0;
      @(posedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic step(input bit r0, input bit r1, input bit v0, input int p0,
                       input bit v1, input int p1, input int cc, input bit fl);
      exp_t e;
      @(posedge clock); #1;
      req0 = r0; req1 = r1; f0v = v0; f0p = preg_t'(p0); f1v = v1; f1p = preg_t'(p1);
      cac = 2'(cc); flush = fl;
      step_id++;
      e.id = step_id;
      e.cnt = freeq.size();
      e.can = (freeq.size() >= 2);
      e.chk_resp = e.can;
      e.r0 = e.can ? freeq[0] : 0;
      e.r1 = e.can ? (r0 ? freeq[1] : freeq[0]) : 0;
      sbq.push_back(e);
      for (int i = 0; i < cc; i++) mapped.push_back(specq.pop_front());
      if (fl) begin
         for (int i = specq.size() - 1; i >= 0; i--) freeq.push_front(specq[i]);
         specq.delete();
      end else if (e.can) begin
         if (r0) specq.push_back(freeq.pop_front());
         if (r1) specq.push_back(freeq.pop_front());
      end
      if (v0) begin freeq.push_back(p0); remove_mapped(p0); end
      if (v1) begin freeq.push_back(p1); remove_mapped(p1); end
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp("count", e.id, int'(count), e.cnt);
            cmp("can_alloc", e.id, int'(can_alloc), int'(e.can));
            if (e.chk_resp) begin
               cmp("resp0", e.id, int'(resp0), e.r0);
               cmp("resp1", e.id, int'(resp1), e.r1);
            end
         end
      end
   end

   initial begin : driver
      bit rr0, rr1, ff0, ff1, fl;
      int cc, nf, i0, i1, p0, p1;

      // Reset state.
      do_reset();
      cmp("rst_count", 0, int'(count), 32);
      cmp("rst_can", 0, int'(can_alloc), 1);
      cmp("rst_resp0", 0, int'(resp0), 32);
      cmp("rst_resp1", 0, int'(resp1), 32);

      // Dual allocation.
      step(1, 1, 0, 0, 0, 0, 0, 0);
      cmp("dual_r0", step_id, int'(resp0), 32);
      cmp("dual_r1", step_id, int'(resp1), 33);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      cmp("dual2_r0", step_id, int'(resp0), 34);
      cmp("dual2_r1", step_id, int'(resp1), 35);
      cmp("dual2_cnt", step_id, int'(count), 30);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("dual3_cnt", step_id, int'(count), 28);

      // Slot 1 alone takes the head tag.
      do_reset();
      step(0, 1, 0, 0, 0, 0, 0, 0);
      cmp("i1only_r1", step_id, int'(resp1), 32);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      cmp("i1only_next_r0", step_id, int'(resp0), 33);

      // Drain to one entry, stall, then a single free re-enables allocation.
      do_reset();
      for (int k = 0; k < 15; k++) step(1, 1, 0, 0, 0, 0, auto_cc(), 0);
      step(1, 0, 0, 0, 0, 0, auto_cc(), 0);
      step(1, 1, 0, 0, 0, 0, auto_cc(), 0);
      cmp("drain_can", step_id, int'(can_alloc), 0);
      cmp("drain_cnt", step_id, int'(count), 1);
      step(1, 1, 1, 5, 0, 0, auto_cc(), 0);
      step(0, 0, 0, 0, 0, 0, auto_cc(), 0);
      cmp("refill_cnt", step_id, int'(count), 2);
      cmp("refill_can", step_id, int'(can_alloc), 1);
      cmp("refill_r0", step_id, int'(resp0), 63);

      // Flush rewinds to the committed head.
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("flush_cnt", step_id, int'(count), 30);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      cmp("flush_r0", step_id, int'(resp0), 34);

      // Simultaneous alloc and free, released tags come back after wrap-around.
      do_reset();
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 7, 1, 9, 2, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("simul_cnt", step_id, int'(count), 30);
      for (int k = 0; k < 14; k++) step(1, 1, 0, 0, 0, 0, auto_cc(), 0);
      step(1, 1, 0, 0, 0, 0, auto_cc(), 0);
      cmp("wrap_r0", step_id, int'(resp0), 7);
      cmp("wrap_r1", step_id, int'(resp1), 9);

`ifndef FREELIST_DUPCHK_EN
      // Without the duplicate checker a repeated release is simply counted.
      do_reset();
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0);
      step(0, 0, 1, 40, 0, 0, 0, 0);
      step(0, 0, 1, 40, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      cmp("dup_cnt", step_id, int'(count), 32);
`endif

      // Randomised legal traffic.
      do_reset();
      for (int n = 0; n < 700; n++) begin
         if (n == 350) do_reset();
         rr0 = 1'($urandom_range(0, 1));
         rr1 = 1'($urandom_range(0, 1));
         cc  = int'($urandom_range(0, auto_cc()));
         fl  = ($urandom_range(0, 15) == 0);
         nf  = int'($urandom_range(0, 2));
         while (nf > 0 && mapped.size() - nf < LREG_NUM - 1) nf--;
         i0 = int'($urandom_range(0, mapped.size() - 1));
         i1 = (i0 + 1 + int'($urandom_range(0, mapped.size() - 2))) % mapped.size();
         p0 = mapped[i0];
         p1 = mapped[i1];
         ff0 = 1'b0; ff1 = 1'b0;
         if (nf == 2) begin
            ff0 = 1'b1; ff1 = 1'b1;
         end else if (nf == 1) begin
            if ($urandom_range(0, 1) == 0) ff0 = 1'b1;
            else begin ff1 = 1'b1; p1 = p0; end
         end
         step(rr0, rr1, ff0, p0, ff1, p1, cc, fl);
      end

      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      if (sbq.size() != 0) cmp("sb_drain", step_id, sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
